// File: rtl/matcher_pkg.sv
// Shared definitions for the matcher filter sequencer: FSM states and record layout.
package matcher_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_EMIT,
      S_ACK,
      S_FIN,
      S_GAP
   } seq_state_t;

   localparam int unsigned DEF_INPUT_STREAM_WIDTH = 512;
   localparam int unsigned DEF_DATA_WIDTH         = 24;
   localparam int unsigned DEF_BEAT_CNT_WIDTH     = 16;

   // Output record is packed as {beat index, byte mask, list entry}.
   function automatic int unsigned record_width(int unsigned stream_w, int unsigned data_w,
                                                int unsigned beat_w);
      return beat_w + stream_w / 8 + data_w;
   endfunction

endpackage

// File: rtl/matcher_filter_seq_if.sv
// Ingress beat stream and match-record egress stream of the sequencer.
interface matcher_filter_seq_if
   import matcher_pkg::*;
#(
   parameter int unsigned INPUT_STREAM_WIDTH = DEF_INPUT_STREAM_WIDTH,
   parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int unsigned BEAT_CNT_WIDTH     = DEF_BEAT_CNT_WIDTH
);
   logic [INPUT_STREAM_WIDTH-1:0]   in_data;
   logic                            in_valid;
   logic                            in_ready;
   logic                            out_valid;
   logic                            out_ready;
   logic [BEAT_CNT_WIDTH-1:0]       out_beat;
   logic [INPUT_STREAM_WIDTH/8-1:0] out_mask;
   logic [DATA_WIDTH-1:0]           out_data;

   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_valid, out_beat, out_mask, out_data
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_valid, out_beat, out_mask, out_data
   );
endinterface

// File: rtl/matcher_out_reg.sv
// Single-entry valid/ready holding register for one match record.
module matcher_out_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // The record stays put after acceptance so idle outputs hold their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/matcher_filter_seq.sv
// Sequencer holding each ingress beat on the matcher filter and draining its matches.
module matcher_filter_seq
   import matcher_pkg::*;
#(
   parameter int unsigned INPUT_STREAM_WIDTH = DEF_INPUT_STREAM_WIDTH,
   parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int unsigned MAX_MATCHES        = 16,
   parameter int unsigned BEAT_CNT_WIDTH     = DEF_BEAT_CNT_WIDTH
) (
   input  logic                                 fclk,
   input  logic                                 areset,
   matcher_filter_seq_if.master                 bus,
   output logic                                 data_valid,
   output logic [INPUT_STREAM_WIDTH-1:0]        input_stream,
   input  logic [INPUT_STREAM_WIDTH/8-1:0]      filter_result,
   input  logic [DATA_WIDTH-1:0]                filter_result_data,
   input  logic                                 filter_result_valid,
   input  logic                                 filter_result_done,
   output logic                                 filter_result_reset,
   output logic                                 beat_done,
   output logic [$clog2(MAX_MATCHES+1)-1:0]     beat_match_cnt,
   output logic                                 beat_trunc
);

   localparam int unsigned CNT_W = $clog2(MAX_MATCHES + 1);
   localparam int unsigned REC_W = record_width(INPUT_STREAM_WIDTH, DATA_WIDTH, BEAT_CNT_WIDTH);

   seq_state_t                state, state_nxt;
   logic [1:0]                rst_pipe;
   logic                      rst_int;
   logic [BEAT_CNT_WIDTH-1:0] beat_idx;
   logic [CNT_W-1:0]          match_cnt;
   logic [CNT_W-1:0]          cnt_inc;
   logic                      trunc;
   logic                      take_beat;
   logic                      load_rec;
   logic                      accept;
   logic                      last_match;
   logic [REC_W-1:0]          rec;

   // Reset asserts asynchronously but releases two clocks after areset falls.
   always_ff @(posedge fclk or posedge areset) begin
      if (areset) rst_pipe <= '1;
      else        rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_int = rst_pipe[1];

   assign bus.in_ready = (state == S_IDLE) && !rst_int;
   assign take_beat    = bus.in_valid && bus.in_ready;
   assign accept       = bus.out_valid && bus.out_ready;
   assign cnt_inc      = match_cnt + 1'b1;
   assign last_match   = (cnt_inc == CNT_W'(MAX_MATCHES));
   assign load_rec     = (state == S_RUN) && filter_result_valid && !filter_result_done;

   always_comb begin
      state_nxt           = state;
      data_valid          = 1'b0;
      filter_result_reset = 1'b0;
      beat_done           = 1'b0;
      unique case (state)
         S_IDLE: if (take_beat) state_nxt = S_RUN;
         S_RUN: begin
            data_valid = 1'b1;
            if (filter_result_done)       state_nxt = S_FIN;
            else if (filter_result_valid) state_nxt = S_EMIT;
         end
         S_EMIT: begin
            data_valid = 1'b1;
            if (accept) state_nxt = last_match ? S_FIN : S_ACK;
         end
         S_ACK: begin
            data_valid          = 1'b1;
            filter_result_reset = 1'b1;
            state_nxt           = S_RUN;
         end
         S_FIN: begin
            beat_done = 1'b1;
            state_nxt = S_GAP;
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge fclk or posedge rst_int) begin
      if (rst_int) begin
         state        <= S_IDLE;
         beat_idx     <= '0;
         match_cnt    <= '0;
         trunc        <= 1'b0;
         input_stream <= '0;
      end else begin
         state <= state_nxt;
         if (take_beat) begin
            input_stream <= bus.in_data;
            match_cnt    <= '0;
            trunc        <= 1'b0;
         end
         if (accept) begin
            match_cnt <= cnt_inc;
            if (last_match) trunc <= 1'b1;
         end
         if (state == S_FIN) beat_idx <= beat_idx + 1'b1;
      end
   end

   assign beat_match_cnt = match_cnt;
   assign beat_trunc     = trunc;

   matcher_out_reg #(
      .WIDTH(REC_W)
   ) u_out_reg (
      .clk      (fclk),
      .rst      (rst_int),
      .load     (load_rec),
      .load_data({beat_idx, filter_result, filter_result_data}),
      .ready    (bus.out_ready),
      .valid    (bus.out_valid),
      .data     (rec)
   );

   assign {bus.out_beat, bus.out_mask, bus.out_data} = rec;

endmodule

// File: tb/tb_matcher_filter_seq.sv
// Randomized bench: behavioural filter model plus per-cycle scoreboard of the sequencer.
module tb_matcher_filter_seq;

   localparam int unsigned IW   = 64;
   localparam int unsigned DW   = 24;
   localparam int unsigned MAXM = 4;
   localparam int unsigned BW   = 2;
   localparam int unsigned MW   = IW / 8;
   localparam int unsigned CW   = $clog2(MAXM + 1);
   localparam int unsigned ND   = 7;

   typedef struct {
      logic [BW-1:0] beat;
      logic [MW-1:0] mask;
      logic [DW-1:0] data;
   } rec_t;

   typedef struct {
      int unsigned cnt;
      bit          trunc;
   } sum_t;

   logic fclk = 1'b0;
   logic areset = 1'b1;
   always #5 fclk = ~fclk;

   logic          data_valid;
   logic [IW-1:0] input_stream;
   logic [MW-1:0] filter_result;
   logic [DW-1:0] filter_result_data;
   logic          filter_result_valid;
   logic          filter_result_done;
   logic          filter_result_reset;
   logic          beat_done;
   logic [CW-1:0] beat_match_cnt;
   logic          beat_trunc;

   matcher_filter_seq_if #(
      .INPUT_STREAM_WIDTH(IW),
      .DATA_WIDTH        (DW),
      .BEAT_CNT_WIDTH    (BW)
   ) bus ();

   matcher_filter_seq #(
      .INPUT_STREAM_WIDTH(IW),
      .DATA_WIDTH        (DW),
      .MAX_MATCHES       (MAXM),
      .BEAT_CNT_WIDTH    (BW)
   ) dut (
      .fclk               (fclk),
      .areset             (areset),
      .bus                (bus),
      .data_valid         (data_valid),
      .input_stream       (input_stream),
      .filter_result      (filter_result),
      .filter_result_data (filter_result_data),
      .filter_result_valid(filter_result_valid),
      .filter_result_done (filter_result_done),
      .filter_result_reset(filter_result_reset),
      .beat_done          (beat_done),
      .beat_match_cnt     (beat_match_cnt),
      .beat_trunc         (beat_trunc)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard state
   rec_t          exp_rec[$];
   sum_t          exp_sum[$];
   logic [IW-1:0] exp_beat_data[$];
   rec_t          rec_log[$];
   sum_t          sum_log[$];
   logic [BW-1:0] model_beat = '0;
   bit            running = 0;
   int            gap = 2;
   int unsigned   acc_cnt = 0;
   bit            pending_ack = 0;
   bit            prev_stall = 0;
   rec_t          prev_rec;
   bit            prev_fv = 0;
   bit            fv_pending = 0;
   bit            hs_seen = 0;
   int            cyc = 0;
   int            last_done_cyc = -1;
   int            gap_meas = -1;

   // Stimulus control
   bit            in_stop = 1;
   bit            in_random = 0;
   bit            ready_hold = 0;
   int            ready_mode = 0;
   int unsigned   dir_idx = 0;
   int unsigned   dir_n[ND] = '{1, 0, 3, 6, 1, 2, 1};
   int unsigned   dir_delay[ND] = '{3, 128, 2, 2, 2, 2, 2};
   logic [MW-1:0] dir_mask[ND][8];
   logic [DW-1:0] dir_data[ND][8];

   // Behavioural matcher filter: scans a list, raises one match at a time, waits for ack.
   initial begin : filter_model
      int            fstate;
      int unsigned   n, idx, delay;
      logic [MW-1:0] lm[8];
      logic [DW-1:0] ld[8];
      bit            dv, rr;
      sum_t          s;
      fstate = 0;
      n = 0; idx = 0; delay = 0;
      filter_result = '0;
      filter_result_data = '0;
      filter_result_valid = 1'b0;
      filter_result_done = 1'b0;
      forever begin
         @(negedge fclk);
         dv = data_valid;
         rr = filter_result_reset;
         @(posedge fclk);
         #1;
         if (!dv) begin
            fstate = 0;
            filter_result_valid = 1'b0;
            filter_result_done = 1'b0;
         end else begin
            case (fstate)
               0: begin
                  if (dir_idx < ND) begin
                     n = dir_n[dir_idx];
                     delay = dir_delay[dir_idx];
                     for (int i = 0; i < 8; i++) begin
                        lm[i] = dir_mask[dir_idx][i];
                        ld[i] = dir_data[dir_idx][i];
                     end
                     dir_idx++;
                  end else begin
                     n = $urandom_range(0, 6);
                     delay = $urandom_range(1, 5);
                     for (int i = 0; i < 8; i++) begin
                        lm[i] = MW'($urandom);
                        ld[i] = DW'($urandom);
                     end
                  end
                  chk("beat_data_avail", 64'(exp_beat_data.size()), 64'd1);
                  if (exp_beat_data.size() > 0) chk("input_stream", input_stream, exp_beat_data.pop_front());
                  for (int unsigned i = 0; i < n && i < MAXM; i++)
                     exp_rec.push_back('{model_beat, lm[i], ld[i]});
                  s.cnt = (n < MAXM) ? n : MAXM;
                  s.trunc = (n >= MAXM);
                  exp_sum.push_back(s);
                  model_beat = model_beat + 1'b1;
                  idx = 0;
                  fstate = 1;
               end
               1: begin
                  if (delay > 1) delay--;
                  else if (idx < n) begin
                     filter_result = lm[idx];
                     filter_result_data = ld[idx];
                     filter_result_valid = 1'b1;
                     fstate = 2;
                  end else begin
                     filter_result_done = 1'b1;
                     fstate = 3;
                  end
               end
               2: if (rr) begin
                  filter_result_valid = 1'b0;
                  idx++;
                  delay = $urandom_range(1, 4);
                  fstate = 1;
               end
               default: ;
            endcase
         end
      end
   end

   // Ingress driver: keeps a beat offered until it is taken.
   initial begin : ingress
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      forever begin
         @(posedge fclk);
         #1;
         if (in_stop) bus.in_valid = 1'b0;
         else if (hs_seen || !bus.in_valid) begin
            bus.in_valid = in_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data = {$urandom, $urandom};
         end
      end
   end

   // Egress ready driver: always-on, random, or five-cycle stall per record.
   initial begin : egress
      int stall;
      stall = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(posedge fclk);
         #1;
         if (ready_hold) bus.out_ready = 1'b0;
         else if (ready_mode == 0) bus.out_ready = 1'b1;
         else if (ready_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
         else if (bus.out_valid) begin
            if (stall == 5) begin
               bus.out_ready = 1'b1;
               stall = 0;
            end else begin
               bus.out_ready = 1'b0;
               stall++;
            end
         end else begin
            bus.out_ready = 1'b0;
            stall = 0;
         end
      end
   end

   // Per-cycle compare against the sequencing rules.
   initial begin : compare
      bit   exp_ready, pa_next;
      rec_t r, act;
      sum_t s;
      forever begin
         @(negedge fclk);
         if (!areset) begin
            cyc++;
            act = '{bus.out_beat, bus.out_mask, bus.out_data};
            if (beat_done) begin
               chk("sum_avail", 64'(exp_sum.size() > 0), 64'd1);
               if (exp_sum.size() > 0) begin
                  s = exp_sum.pop_front();
                  chk("beat_match_cnt", 64'(beat_match_cnt), 64'(s.cnt));
                  chk("beat_trunc", 64'(beat_trunc), 64'(s.trunc));
               end
               sum_log.push_back('{int'(beat_match_cnt), beat_trunc});
               running = 0;
               gap = 2;
               acc_cnt = 0;
               pending_ack = 0;
               last_done_cyc = cyc;
            end
            exp_ready = !running && (gap == 0);
            chk("data_valid", 64'(data_valid), 64'(running));
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            chk("filter_result_reset", 64'(filter_result_reset), 64'(pending_ack));
            chk("out_valid_outside_beat", 64'(bus.out_valid && !running), 64'd0);
            if (fv_pending) chk("out_valid_latency", 64'(bus.out_valid), 64'd1);
            fv_pending = filter_result_valid && !prev_fv && running;
            prev_fv = filter_result_valid;
            if (prev_stall) begin
               chk("hold_valid", 64'(bus.out_valid), 64'd1);
               chk("hold_record", 64'({act.beat, act.mask, act.data}),
                   64'({prev_rec.beat, prev_rec.mask, prev_rec.data}));
            end
            pa_next = 0;
            if (bus.out_valid && bus.out_ready) begin
               chk("rec_avail", 64'(exp_rec.size() > 0), 64'd1);
               if (exp_rec.size() > 0) begin
                  r = exp_rec.pop_front();
                  chk("out_beat", 64'(act.beat), 64'(r.beat));
                  chk("out_mask", 64'(act.mask), 64'(r.mask));
                  chk("out_data", 64'(act.data), 64'(r.data));
               end
               rec_log.push_back(act);
               acc_cnt++;
               pa_next = (acc_cnt < MAXM);
            end
            pending_ack = pa_next;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_rec = act;
            if (gap > 0) gap--;
            hs_seen = 0;
            if (bus.in_valid && exp_ready) begin
               exp_beat_data.push_back(bus.in_data);
               running = 1;
               hs_seen = 1;
               if (gap_meas < 0 && last_done_cyc >= 0) gap_meas = cyc - last_done_cyc;
            end
         end
      end
   end

   task automatic wait_sums(input int n, input int budget);
      int k = 0;
      while (sum_log.size() < n && k < budget) begin
         @(negedge fclk);
         k++;
      end
      chk("wait_beats", 64'(sum_log.size() >= n), 64'd1);
   endtask

   task automatic release_reset();
      @(posedge fclk);
      #2;
      gap = 2;
      areset = 1'b0;
   endtask

   initial begin : main
      int post_idx;
      int k;
      for (int d = 0; d < ND; d++)
         for (int i = 0; i < 8; i++) begin
            dir_mask[d][i] = MW'($urandom);
            dir_data[d][i] = DW'($urandom);
         end
      dir_mask[0][0] = 8'h04;
      dir_data[0][0] = 24'hABCDEF;

      repeat (4) @(posedge fclk);
      #1;
      chk("rst_data_valid", 64'(data_valid), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_input_stream", input_stream, 64'd0);
      chk("rst_flt_reset", 64'(filter_result_reset), 64'd0);
      chk("rst_beat_cnt", 64'(beat_match_cnt), 64'd0);
      release_reset();
      in_stop = 0;

      ready_mode = 0;
      wait_sums(2, 2000);
      ready_mode = 2;
      wait_sums(3, 2000);
      ready_mode = 1;
      wait_sums(5, 2000);
      ready_hold = 1;

      k = 0;
      while (!bus.out_valid && k < 2000) begin
         @(negedge fclk);
         k++;
      end
      chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      #2;
      areset = 1'b1;
      in_stop = 1;
      bus.in_valid = 1'b0;
      #1;
      chk("async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_data_valid", 64'(data_valid), 64'd0);
      chk("async_flt_reset", 64'(filter_result_reset), 64'd0);
      exp_rec.delete();
      exp_sum.delete();
      exp_beat_data.delete();
      model_beat = '0;
      running = 0;
      acc_cnt = 0;
      pending_ack = 0;
      prev_stall = 0;
      fv_pending = 0;
      prev_fv = 0;
      post_idx = rec_log.size();
      repeat (3) @(posedge fclk);
      ready_hold = 0;
      release_reset();
      in_stop = 0;

      wait_sums(6, 2000);
      in_random = 1;
      wait_sums(46, 20000);
      in_stop = 1;
      repeat (300) @(negedge fclk);
      chk("drain_records", 64'(exp_rec.size()), 64'd0);
      chk("drain_summaries", 64'(exp_sum.size()), 64'd0);

      // Literal pins on the directed beats.
      chk("log_sizes", 64'(rec_log.size() > post_idx && post_idx >= 9 && sum_log.size() >= 5), 64'd1);
      if (rec_log.size() > post_idx && post_idx >= 9 && sum_log.size() >= 5) begin
         chk("lit_first_beat", 64'(rec_log[0].beat), 64'd0);
         chk("lit_first_mask", 64'(rec_log[0].mask), 64'h04);
         chk("lit_first_data", 64'(rec_log[0].data), 64'hABCDEF);
         chk("lit_sum0_cnt", 64'(sum_log[0].cnt), 64'd1);
         chk("lit_sum1_cnt", 64'(sum_log[1].cnt), 64'd0);
         chk("lit_sum1_trunc", 64'(sum_log[1].trunc), 64'd0);
         chk("lit_sum2_cnt", 64'(sum_log[2].cnt), 64'd3);
         chk("lit_sum3_cnt", 64'(sum_log[3].cnt), 64'd4);
         chk("lit_sum3_trunc", 64'(sum_log[3].trunc), 64'd1);
         chk("lit_beat_wrap", 64'(rec_log[8].beat), 64'd0);
         chk("lit_post_reset_beat", 64'(rec_log[post_idx].beat), 64'd0);
      end
      chk("lit_b2b_gap", 64'(gap_meas), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matcher_filter_seq.md
Name: matcher_filter_seq

Overview:
- Sequencer that drives one matcher filter instance: accepts input beats over a valid/ready stream and holds each beat on the filter's `input_stream`/`data_valid` while the filter scans its list.
- Drains every match the filter reports into an output record stream (valid/ready, single holding register), then pulses `filter_result_reset` to resume the scan.
- When the filter reports done, releases `data_valid` and reports a per-beat summary.
- Sits between the stream ingress (DMA/GPIO front end) and the filter/list-memory pair.

Parameters:
- INPUT_STREAM_WIDTH, 512, beat width in bits; mask width = INPUT_STREAM_WIDTH/8.
- DATA_WIDTH, 24, width of filter list entry returned per match.
- MAX_MATCHES, 16, matches emitted per beat before truncation.
- BEAT_CNT_WIDTH, 16, width of beat index counter.

Ports:
- fclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- in_data  in  INPUT_STREAM_WIDTH  ingress beat.
- in_valid  in  1  ingress beat valid.
- in_ready  out  1  sequencer can take a beat.
- data_valid  out  1  to filter: beat present.
- input_stream  out  INPUT_STREAM_WIDTH  to filter: held beat.
- filter_result  in  INPUT_STREAM_WIDTH/8  from filter: byte-offset match mask.
- filter_result_data  in  DATA_WIDTH  from filter: matched list entry.
- filter_result_valid  in  1  from filter: match pending.
- filter_result_done  in  1  from filter: list exhausted.
- filter_result_reset  out  1  to filter: one-cycle match acknowledge.
- out_valid  out  1  match record valid.
- out_ready  in  1  downstream accepts record.
- out_beat  out  BEAT_CNT_WIDTH  beat index of record.
- out_mask  out  INPUT_STREAM_WIDTH/8  match mask.
- out_data  out  DATA_WIDTH  matched entry.
- beat_done  out  1  one-cycle pulse, beat finished.
- beat_match_cnt  out  $clog2(MAX_MATCHES+1)  matches in finished beat; valid with `beat_done`.
- beat_trunc  out  1  finished beat hit MAX_MATCHES; valid with `beat_done`.

Behaviour:
- Reset (async assert, sync deassert internally):
  - outputs low/zero, `input_stream` = 0, beat index = 0, state S_IDLE.
  - `in_ready` = 1 is combinational from S_IDLE.
- S_IDLE: `in_ready` = 1. On `in_valid` & `in_ready`:
  - latch `in_data` into the hold register and drive it on `input_stream`.
  - clear the match count; `data_valid` = 1 from the next cycle; go S_RUN.
- S_RUN: `data_valid` = 1.
  - `filter_result_done` = 1 → go S_FIN. Done has priority if sampled together with valid (cannot occur from a correct filter).
  - `filter_result_valid` = 1 → capture `filter_result`, `filter_result_data` and the beat index into the output register; set `out_valid`; go S_EMIT.
- S_EMIT: `out_valid` = 1, record stable until `out_ready`.
  - On `out_valid` & `out_ready`: clear `out_valid` and increment the match count.
  - If the count then equals MAX_MATCHES: set the trunc flag and go S_FIN without acknowledging the filter.
  - Otherwise go S_ACK.
- S_ACK: `filter_result_reset` = 1 for exactly one cycle; go S_RUN.
  - The filter drops `filter_result_valid` the next cycle and resumes from the following list address.
- S_FIN:
  - `data_valid` = 0; pulse `beat_done` with `beat_match_cnt`/`beat_trunc`.
  - Beat index += 1, wrapping modulo 2^BEAT_CNT_WIDTH.
  - Go S_GAP.
- S_GAP: `data_valid` = 0 for one more cycle so the filter reaches idle; `in_ready` = 0; go S_IDLE.
- Minimum gap between beats: `data_valid` low ≥ 2 cycles.
- Latencies:
  - ingress handshake → `data_valid`: 1 cycle.
  - `filter_result_valid` → `out_valid`: 1 cycle.
  - `out_ready` accept → `filter_result_reset`: 1 cycle.
- Truncation: the filter is left in its wait state. `data_valid` low in S_FIN returns it to idle; no reset pulse is issued.
- `beat_match_cnt` saturates at MAX_MATCHES.
- Reset mid-operation: all state cleared and any held record discarded. The filter sees `data_valid` = 0 and returns to idle on its own.
- `out_*` fields hold their last value when `out_valid` = 0; `in_data` is sampled only on the handshake.

Decomposition:
- Shared package `matcher_pkg`: state encoding constants (S_IDLE..S_GAP) and the match record field widths, shared with the output-packing logic.
- One natural sub-module: `matcher_out_reg`, a single-entry valid/ready holding register for the record.

Test Plan:
- Beat with zero matches: filter done after 128 compares.
  - `out_valid` never asserts.
  - `beat_done` pulses with cnt = 0, trunc = 0.
  - `data_valid` low 2 cycles, then `in_ready` = 1.
- One match (mask = 0x0000_0004, data = 0xABCDEF), `out_ready` = 1:
  - one record with out_beat = 0, out_mask = 0x4, out_data = 0xABCDEF.
  - `filter_result_reset` pulses exactly one cycle, 1 cycle after accept.
  - `beat_done` cnt = 1.
- Three matches with `out_ready` low 5 cycles on each:
  - each record held stable while stalled; no `filter_result_reset` until accept.
  - cnt = 3, records in list order.
- MAX_MATCHES = 2 with 4 pending matches:
  - 2 records emitted, then `beat_done` with cnt = 2, trunc = 1.
  - no second reset pulse; `data_valid` drops.
- Back-to-back beats with `in_valid` held high:
  - second beat accepted 2 cycles after `beat_done`.
  - out_beat increments 0 → 1; with BEAT_CNT_WIDTH = 2, wraps 3 → 0.
- `areset` asserted while in S_EMIT with `out_valid` = 1:
  - `out_valid`, `data_valid` and `filter_result_reset` go 0 immediately (async).
  - after release, `in_ready` = 1 and beat index = 0.
